mm_stream_port: RTL and testbench

Streaming front/back end for the combinational `matrixMultiplier`. Accepts operand matrices A and B one element per handshake, assembles them into the packed 64-bit operand words driven onto the multiplier's `i0`/`i1` inputs, and captures the packed product `o`. It then streams the product back out one element per handshake. It sits between the system's element stream and the multiplier and replaces direct, bench-style packed-vector driving.

---
 rtl/mm_stream_port_pkg.sv | 23 ++
 rtl/mm_stream_port_if.sv | 29 ++
 rtl/mm_stream_port.sv | 121 ++++++++++++
 tb/tb_mm_stream_port.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mm_stream_port_pkg.sv
// Shared constants, state encoding and slot addressing for mm_stream_port.
package mm_pkg;

  localparam int ELEM_W = 4;
  localparam int DIM    = 4;
  localparam int N      = DIM * DIM;
  localparam int PACK_W = N * ELEM_W;
  localparam int IDX_W  = $clog2(N);
  localparam int LSB_W  = $clog2(PACK_W);

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } mm_state_t;

  // Bit offset of row-major element idx inside a packed matrix word.
  function automatic logic [LSB_W-1:0] slot_lsb(input logic [IDX_W-1:0] idx);
    return LSB_W'(ELEM_W) * LSB_W'(idx);
  endfunction

endpackage

// File: rtl/mm_stream_port_if.sv
// Element-stream and multiplier-side signals of mm_stream_port.
// slave is the port block itself; master is whoever drives the streams
// and hosts the combinational multiplier.
interface mm_stream_port_if;
  import mm_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [ELEM_W-1:0] in_data;
  logic [PACK_W-1:0] mm_a;
  logic [PACK_W-1:0] mm_b;
  logic [PACK_W-1:0] mm_o;
  logic              out_valid;
  logic              out_ready;
  logic [ELEM_W-1:0] out_data;
  logic              out_last;
  logic              busy;

  modport slave (
    input  in_valid, in_data, mm_o, out_ready,
    output in_ready, mm_a, mm_b, out_valid, out_data, out_last, busy
  );

  modport master (
    output in_valid, in_data, mm_o, out_ready,
    input  in_ready, mm_a, mm_b, out_valid, out_data, out_last, busy
  );

endinterface

// File: rtl/mm_stream_port.sv
// Streams A then B into packed operand words for the matrix multiplier,
// captures the packed product and streams it back out element by element.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   LOAD_A  | accept N elements of A into mm_a, row-major
//   LOAD_B  | accept N elements of B into mm_b, row-major
//   COMPUTE | one cycle: register multiplier product into result register
//   DRAIN   | present result elements, advance on each output handshake
module mm_stream_port
  import mm_pkg::*;
(
  input logic             clk,
  input logic             reset,
  mm_stream_port_if.slave bus
);

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_PENUL = IDX_W'(N - 2);

  mm_state_t         r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [PACK_W-1:0] r_mm_a;
  logic [PACK_W-1:0] r_mm_b;
  logic [PACK_W-1:0] r_res;
  logic              r_load;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_busy;

  logic [LSB_W-1:0]  w_lsb;
  logic              w_in_ready;
  logic              w_in_hs;
  logic              w_out_hs;
  logic              w_idx_last;

  // r_load is set during reset so in_ready rises as soon as reset releases;
  // gating with reset keeps it low while reset is held.
  assign w_lsb      = slot_lsb(r_idx);
  assign w_in_ready = r_load & reset;
  assign w_in_hs    = bus.in_valid & w_in_ready;
  assign w_out_hs   = r_out_valid & bus.out_ready;
  assign w_idx_last = (r_idx == IDX_LAST);

  assign bus.in_ready  = w_in_ready;
  assign bus.mm_a      = r_mm_a;
  assign bus.mm_b      = r_mm_b;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_res[w_lsb +: ELEM_W];
  assign bus.out_last  = r_out_last;
  assign bus.busy      = r_busy;

  // Sequencing FSM with registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= LOAD_A;
      r_idx       <= '0;
      r_mm_a      <= '0;
      r_mm_b      <= '0;
      r_res       <= '0;
      r_load      <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        LOAD_A: begin
          if (w_in_hs) begin
            r_mm_a[w_lsb +: ELEM_W] <= bus.in_data;
            if (w_idx_last) begin
              r_idx   <= '0;
              r_state <= LOAD_B;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (w_in_hs) begin
            r_mm_b[w_lsb +: ELEM_W] <= bus.in_data;
            if (w_idx_last) begin
              r_idx   <= '0;
              r_state <= COMPUTE;
              r_load  <= 1'b0;
              r_busy  <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        COMPUTE: begin
          r_res       <= bus.mm_o;
          r_idx       <= '0;
          r_state     <= DRAIN;
          r_out_valid <= 1'b1;
          r_out_last  <= 1'b0;
        end
        DRAIN: begin
          if (w_out_hs) begin
            if (w_idx_last) begin
              r_idx       <= '0;
              r_state     <= LOAD_A;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_busy      <= 1'b0;
              r_load      <= 1'b1;
            end else begin
              r_idx      <= r_idx + 1'b1;
              r_out_last <= (r_idx == IDX_PENUL);
            end
          end
        end
        default: begin
          r_state <= LOAD_A;
          r_idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mm_stream_port.sv
// Bench for mm_stream_port: hosts a behavioural 4x4 multiplier on mm_o and
// checks packing, product streaming, handshakes, gaps, stalls and reset.
module tb_mm_stream_port;
  import mm_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  mm_stream_port_if bus ();

  mm_stream_port dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference matrix product, row-major nibbles, sums taken modulo 16.
  function automatic logic [63:0] matmul(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] o;
    int s;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        s = 0;
        for (int k = 0; k < 4; k++)
          s += int'(a[4*(4*r+k) +: 4]) * int'(b[4*(4*k+c) +: 4]);
        o[4*(4*r+c) +: 4] = 4'(s % 16);
      end
    end
    return o;
  endfunction

  // Stand-in for the combinational multiplier at the next level up.
  always_comb bus.mm_o = matmul(bus.mm_a, bus.mm_b);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sends the first n of the 32 elements (A then B); called at a negedge.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input bit gap, input int n);
    for (int k = 0; k < n; k++) begin
      if (gap && (k % 2 == 1)) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = (k < 16) ? a[4*k +: 4] : b[4*(k-16) +: 4];
      #1 chk("in_ready_load", bus.in_ready, 1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input logic [63:0] exp, input bit bp, input bit junk);
    int   k;
    int   cyc;
    logic rdy;
    k   = 0;
    cyc = 0;
    while (k < 16 && cyc < 300) begin
      rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.out_ready = rdy;
      if (junk) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 4'($urandom);
      end
      #1;
      chk("out_valid", bus.out_valid, 1);
      chk("out_data", bus.out_data, exp[4*k +: 4]);
      chk("out_last", bus.out_last, (k == 15));
      chk("busy_drain", bus.busy, 1);
      if (junk) chk("in_ready_drain", bus.in_ready, 0);
      if (rdy) k++;
      cyc++;
      @(negedge clk);
    end
    if (k < 16) chk("drain_timeout", k, 16);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    #1;
    chk("in_ready_after_drain", bus.in_ready, 1);
    chk("busy_after_drain", bus.busy, 0);
    chk("out_valid_after_drain", bus.out_valid, 0);
  endtask

  task automatic run_txn(input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                         input bit gap, input bit bp, input bit junk);
    send(a, b, gap, 32);
    #1;
    chk("mm_a_packed", bus.mm_a, a);
    chk("mm_b_packed", bus.mm_b, b);
    chk("busy_compute", bus.busy, 1);
    chk("in_ready_compute", bus.in_ready, 0);
    chk("out_valid_compute", bus.out_valid, 0);
    @(negedge clk);
    drain(exp, bp, junk);
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp_o;
    bit          gap;
    bit          bp;
    bit          junk;
  } vec_t;

  localparam logic [63:0] IDENT = 64'h1000_0100_0010_0001;
  localparam logic [63:0] RAMP  = 64'hFEDC_BA98_7654_3210;

  vec_t vecs [6];

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{IDENT, RAMP, RAMP, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h4444_4444_4444_4444, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{IDENT, RAMP, RAMP, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{IDENT, RAMP, RAMP, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{RAMP, IDENT, RAMP, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{64'h2000_0200_0020_0002, RAMP, 64'hECA8_6420_ECA8_6420, 1'b1, 1'b1, 1'b1};

    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_mm_a", bus.mm_a, 0);
    chk("rst_mm_b", bus.mm_b, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_busy", bus.busy, 0);
    reset = 1'b1;
    #1 chk("in_ready_release", bus.in_ready, 1);

    // Table vectors run back-to-back: each load starts the cycle after out_last.
    for (int i = 0; i < 6; i++)
      run_txn(vecs[i].a, vecs[i].b, vecs[i].exp_o, vecs[i].gap, vecs[i].bp, vecs[i].junk);

    // Reset after all of A and 7 elements of B, then a clean transaction.
    send(IDENT, RAMP, 1'b0, 23);
    reset = 1'b0;
    #1 chk("in_ready_in_reset", bus.in_ready, 0);
    @(negedge clk);
    #1;
    chk("midrst_mm_a", bus.mm_a, 0);
    chk("midrst_mm_b", bus.mm_b, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_out_valid", bus.out_valid, 0);
    reset = 1'b1;
    #1 chk("midrst_in_ready_release", bus.in_ready, 1);
    run_txn(IDENT, RAMP, RAMP, 1'b0, 1'b0, 1'b0);

    // Randomized operands against the reference product.
    for (int i = 0; i < 4; i++) begin
      logic [63:0] ra;
      logic [63:0] rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      run_txn(ra, rb, matmul(ra, rb), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
